// File: rtl/ie_defs.sv
// Shared definitions for the 6502 instruction-execute datapath: sequencer state
// and instruction class encodings, stack beat counts and bus select constants.
package ie_defs;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      MRD  = 4'd1,
      ALU  = 4'd2,
      MWR  = 4'd3,
      PUSH = 4'd4,
      PINC = 4'd5,
      PULL = 4'd6,
      BRN  = 4'd7,
      JUMP = 4'd8,
      DONE = 4'd9
   } seq_state_t;

   typedef enum logic [3:0] {
      NOP    = 4'd0,
      FLAG   = 4'd1,
      DATA   = 4'd2,
      PUSH1  = 4'd3,
      PULL1  = 4'd4,
      JSR    = 4'd5,
      RTS    = 4'd6,
      RTI    = 4'd7,
      BRK    = 4'd8,
      BRANCH = 4'd9
   } seq_class_t;

   localparam logic [1:0] JSR_BEATS    = 2'd2;
   localparam logic [1:0] BRK_BEATS    = 2'd3;
   localparam logic [1:0] RTS_BEATS    = 2'd2;
   localparam logic [1:0] RTI_BEATS    = 2'd3;
   localparam logic       MEMSEL_OPER  = 1'b0;
   localparam logic       MEMSEL_STACK = 1'b1;

   // Number of stack beats an instruction class performs (single push/pull = 1).
   function automatic logic [1:0] total_beats(input seq_class_t cls);
      case (cls)
         JSR:     total_beats = JSR_BEATS;
         BRK:     total_beats = BRK_BEATS;
         RTS:     total_beats = RTS_BEATS;
         RTI:     total_beats = RTI_BEATS;
         default: total_beats = 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/ie_seq_class.sv
// Priority encoder from the decoder's class flags to a single sequencer class.
module ie_seq_class
   import ie_defs::*;
(
   input  logic       is_branch,
   input  logic       is_jsr,
   input  logic       is_rts,
   input  logic       is_rti,
   input  logic       is_break,
   input  logic       is_stack_op,
   input  logic       stack_pull,
   input  logic       is_nop,
   input  logic       is_flag_inst,
   output seq_class_t cls
);

   // Highest-priority flag wins; anything unflagged is a plain data op.
   always_comb begin
      cls = DATA;
      if (is_break)          cls = BRK;
      else if (is_rti)       cls = RTI;
      else if (is_rts)       cls = RTS;
      else if (is_jsr)       cls = JSR;
      else if (is_stack_op)  cls = stack_pull ? PULL1 : PUSH1;
      else if (is_branch)    cls = BRANCH;
      else if (is_nop)       cls = NOP;
      else if (is_flag_inst) cls = FLAG;
      else                   cls = DATA;
   end

endmodule

// File: rtl/ie_sequencer.sv
// Cycle-level controller for the IE datapath: walks one decoded instruction through
// its bus, ALU, stack and PC-load cycles and owns the bus handshake and SP strobes.
module ie_sequencer
   import ie_defs::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       is_load,
   input  logic       is_store,
   input  logic       is_branch,
   input  logic       is_jsr,
   input  logic       is_rts,
   input  logic       is_rti,
   input  logic       is_break,
   input  logic       is_stack_op,
   input  logic       is_nop,
   input  logic       is_flag_inst,
   input  logic       stack_pull,
   input  logic       branch_taken,
   input  logic       mem_ack,
   output logic       ready,
   output logic       done,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_sel,
   output logic       alu_en,
   output logic       wb_en,
   output logic       sp_inc,
   output logic       sp_dec,
   output logic       pc_load,
   output logic [1:0] stk_idx
);

   seq_state_t state_r, state_nx_s, entry_s;
   seq_class_t cls_r, cls_s;
   logic       load_r, store_r;
   logic [1:0] beat_r;
   logic [2:0] beat_inc_s;
   logic       last_beat_s, accept_s, beat_ack_s;

   ie_seq_class u_class (
      .is_branch   (is_branch),
      .is_jsr      (is_jsr),
      .is_rts      (is_rts),
      .is_rti      (is_rti),
      .is_break    (is_break),
      .is_stack_op (is_stack_op),
      .stack_pull  (stack_pull),
      .is_nop      (is_nop),
      .is_flag_inst(is_flag_inst),
      .cls         (cls_s)
   );

   assign accept_s    = start && (state_r == IDLE);
   assign beat_ack_s  = mem_ack && ((state_r == PUSH) || (state_r == PULL));
   assign beat_inc_s  = {1'b0, beat_r} + 3'd1;
   assign last_beat_s = beat_inc_s >= {1'b0, total_beats(cls_r)};

   // First action state for a freshly accepted instruction.
   always_comb begin
      entry_s = DONE;
      case (cls_s)
         NOP:       entry_s = DONE;
         FLAG:      entry_s = ALU;
         DATA:      entry_s = is_load ? MRD : ALU;
         PUSH1:     entry_s = ALU;
         PULL1:     entry_s = PINC;
         JSR, BRK:  entry_s = PUSH;
         RTS, RTI:  entry_s = PINC;
         BRANCH:    entry_s = BRN;
         default:   entry_s = DONE;
      endcase
   end

   // Next-state transitions; bus states wait for mem_ack.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: if (start) state_nx_s = entry_s; else state_nx_s = IDLE;
         MRD:  if (mem_ack) state_nx_s = ALU; else state_nx_s = MRD;
         ALU: begin
            if (cls_r == PUSH1)                  state_nx_s = PUSH;
            else if ((cls_r == DATA) && store_r) state_nx_s = MWR;
            else                                 state_nx_s = DONE;
         end
         MWR:  if (mem_ack) state_nx_s = DONE; else state_nx_s = MWR;
         PUSH: begin
            if (!mem_ack)            state_nx_s = PUSH;
            else if (!last_beat_s)   state_nx_s = PUSH;
            else if (cls_r == PUSH1) state_nx_s = DONE;
            else                     state_nx_s = JUMP;
         end
         PINC: state_nx_s = PULL;
         PULL: begin
            if (!mem_ack)            state_nx_s = PULL;
            else if (!last_beat_s)   state_nx_s = PINC;
            else if (cls_r == PULL1) state_nx_s = ALU;
            else                     state_nx_s = JUMP;
         end
         BRN:     state_nx_s = DONE;
         JUMP:    state_nx_s = DONE;
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register, latched class and stack beat counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cls_r   <= NOP;
         load_r  <= 1'b0;
         store_r <= 1'b0;
         beat_r  <= 2'd0;
      end else begin
         state_r <= state_nx_s;
         if (accept_s) begin
            cls_r   <= cls_s;
            load_r  <= is_load;
            store_r <= is_store;
            beat_r  <= 2'd0;
         end else if (beat_ack_s && (beat_r != 2'd3)) begin
            beat_r  <= beat_r + 2'd1;
         end else begin
            beat_r  <= beat_r;
         end
      end
   end

   // Output decode of the state register; strobes qualify with ack or branch result.
   always_comb begin
      ready   = 1'b0;
      done    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_sel = MEMSEL_OPER;
      alu_en  = 1'b0;
      wb_en   = 1'b0;
      sp_inc  = 1'b0;
      sp_dec  = 1'b0;
      pc_load = 1'b0;
      case (state_r)
         IDLE: ready = 1'b1;
         MRD:  mem_req = 1'b1;
         ALU: begin
            alu_en = 1'b1;
            wb_en  = (cls_r == PULL1) || ((cls_r == DATA) && !store_r);
         end
         MWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         PUSH: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            mem_sel = MEMSEL_STACK;
            sp_dec  = mem_ack;
         end
         PINC: sp_inc = 1'b1;
         PULL: begin
            mem_req = 1'b1;
            mem_sel = MEMSEL_STACK;
         end
         BRN:     pc_load = branch_taken;
         JUMP:    pc_load = 1'b1;
         DONE:    done = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign stk_idx = beat_r;

   // load_r is kept for datapath visibility; the path choice was made at accept.
   logic unused_s;
   assign unused_s = load_r;

endmodule

// File: tb/tb_ie_sequencer.sv
// Scoreboard bench for ie_sequencer: each scenario queues per-cycle expected output
// vectors and bus acks, then pops and compares one vector per clock.
module tb_ie_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] flags = 11'd0;
   logic        branch_taken = 1'b0;
   logic        mem_ack = 1'b0;
   logic        ready, done, mem_req, mem_we, mem_sel, alu_en, wb_en;
   logic        sp_inc, sp_dec, pc_load;
   logic [1:0]  stk_idx;
   logic [11:0] obs;
   logic [11:0] exp_v;
   logic [11:0] exp_q[$];
   logic        ack_q[$];
   int          errors = 0;
   int          checks = 0;

   localparam logic [10:0] F_LOAD  = 11'h400;
   localparam logic [10:0] F_STORE = 11'h200;
   localparam logic [10:0] F_BRNCH = 11'h100;
   localparam logic [10:0] F_JSR   = 11'h080;
   localparam logic [10:0] F_RTI   = 11'h020;
   localparam logic [10:0] F_BRK   = 11'h010;
   localparam logic [10:0] F_STACK = 11'h008;
   localparam logic [10:0] F_NOP   = 11'h004;
   localparam logic [10:0] F_FLAG  = 11'h002;
   localparam logic [10:0] F_PULL  = 11'h001;

   always #5 clk = ~clk;

   ie_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .is_load(flags[10]), .is_store(flags[9]), .is_branch(flags[8]), .is_jsr(flags[7]),
      .is_rts(flags[6]), .is_rti(flags[5]), .is_break(flags[4]), .is_stack_op(flags[3]),
      .is_nop(flags[2]), .is_flag_inst(flags[1]), .stack_pull(flags[0]),
      .branch_taken(branch_taken), .mem_ack(mem_ack),
      .ready(ready), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .alu_en(alu_en), .wb_en(wb_en), .sp_inc(sp_inc), .sp_dec(sp_dec),
      .pc_load(pc_load), .stk_idx(stk_idx)
   );

   assign obs = {ready, done, mem_req, mem_we, mem_sel, alu_en, wb_en,
                 sp_inc, sp_dec, pc_load, stk_idx};

   // Expected vector: ready done req we sel alu wb inc dec pc idx
   function automatic logic [11:0] ev(input logic r, d, rq, we, sel, alu, wb, inc, dec, pc,
                                      input logic [1:0] idx);
      ev = {r, d, rq, we, sel, alu, wb, inc, dec, pc, idx};
   endfunction

   function automatic logic [11:0] idle_v(input logic [1:0] idx);
      idle_v = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idx);
   endfunction

   function automatic logic [11:0] done_v(input logic [1:0] idx);
      done_v = ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idx);
   endfunction

   task automatic accept(input logic [10:0] f);
      @(negedge clk);
      mem_ack = 1'b0;
      flags   = f;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flags = 11'd0;
   endtask

   task automatic expect_cycle(input logic [11:0] v, input logic ack);
      exp_q.push_back(v);
      ack_q.push_back(ack);
   endtask

   task automatic test_reset;
      #1;
      exp_v = idle_v(2'd0);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_state got %b want %b", obs, exp_v);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_beat;
      accept(F_LOAD);
      @(negedge clk);
      #1;
      exp_v = ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mrd_wait got %b want %b", obs, exp_v);
      end
      #2;
      reset_n = 1'b0;
      #1;
      exp_v = idle_v(2'd0);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_beat got %b want %b", obs, exp_v);
      end
      @(negedge clk);
      reset_n = 1'b1;
      accept(F_NOP);
      expect_cycle(done_v(2'd0), 1'b0);
      expect_cycle(idle_v(2'd0), 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         mem_ack = ack_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL nop_after_reset cyc n+%0d got %b want %b", c, obs, exp_v);
         end
      end
   endtask

   // Generic sequence scenario: accept flags, then replay queued acks and compare.
   task automatic test_sequence(input string name, input logic [10:0] f, input logic bt);
      branch_taken = bt;
      accept(f);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         mem_ack = ack_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s cyc n+%0d got %b want %b", name, c, obs, exp_v);
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_load_wait;
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(done_v(2'd0), 1'b0);
      expect_cycle(idle_v(2'd0), 1'b0);
      test_sequence("lda_wait2", F_LOAD, 1'b0);
   endtask

   task automatic test_rmw;
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(done_v(2'd0), 1'b0);
      expect_cycle(idle_v(2'd0), 1'b0);
      test_sequence("inc_rmw", F_LOAD | F_STORE, 1'b0);
   endtask

   task automatic test_store_push_pull;
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(done_v(2'd0), 1'b0);
      test_sequence("sta_wait1", F_STORE, 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0), 1'b1);
      expect_cycle(done_v(2'd1), 1'b0);
      expect_cycle(idle_v(2'd1), 1'b0);
      test_sequence("pha", F_STACK, 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1), 1'b0);
      expect_cycle(done_v(2'd1), 1'b0);
      test_sequence("pla", F_STACK | F_PULL, 1'b0);
   endtask

   task automatic test_jsr;
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2), 1'b0);
      expect_cycle(done_v(2'd2), 1'b0);
      expect_cycle(idle_v(2'd2), 1'b0);
      test_sequence("jsr", F_JSR, 1'b0);
   endtask

   task automatic test_rti;
      for (int b = 0; b < 3; b++) begin
         expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(b)), 1'b0);
         expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(b)), 1'b1);
      end
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3), 1'b0);
      expect_cycle(done_v(2'd3), 1'b0);
      expect_cycle(idle_v(2'd3), 1'b0);
      test_sequence("rti", F_RTI, 1'b0);
   endtask

   task automatic test_branch_and_priority;
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b0);
      expect_cycle(done_v(2'd0), 1'b0);
      test_sequence("beq_not_taken", F_BRNCH, 1'b0);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0), 1'b0);
      expect_cycle(done_v(2'd0), 1'b0);
      test_sequence("beq_taken", F_BRNCH, 1'b1);
      branch_taken = 1'b0;
      for (int b = 0; b < 3; b++)
         expect_cycle(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'(b)), 1'b1);
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3), 1'b0);
      expect_cycle(done_v(2'd3), 1'b0);
      expect_cycle(idle_v(2'd3), 1'b0);
      test_sequence("brk_over_nop", F_BRK | F_NOP, 1'b0);
   endtask

   // Start held through a busy flag op is ignored, then accepted once ready returns.
   task automatic test_back_to_back;
      accept(F_FLAG);
      start = 1'b1;
      flags = F_NOP;
      expect_cycle(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), 1'b1);
      expect_cycle(done_v(2'd0), 1'b1);
      expect_cycle(idle_v(2'd0), 1'b0);
      expect_cycle(done_v(2'd0), 1'b0);
      expect_cycle(idle_v(2'd0), 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         mem_ack = ack_q.pop_front();
         if (c == 4) begin
            start = 1'b0;
            flags = 11'd0;
         end
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cyc n+%0d got %b want %b", c, obs, exp_v);
         end
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_beat();
      test_load_wait();
      test_rmw();
      test_store_push_pull();
      test_jsr();
      test_rti();
      test_branch_and_priority();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
